// File: rtl/range_sensor_pkg.sv
// Shared types and register map for the range-sensor slot responder.
package range_sensor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_e;

   localparam logic [2:0] REG_STATUS = 3'd0;
   localparam logic [2:0] REG_WIDTH  = 3'd1;
   localparam logic [2:0] REG_COUNT  = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd0;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_DONE    = 1;
   localparam int unsigned ST_TIMEOUT = 2;
   localparam int unsigned ST_AUTO    = 3;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_AUTO  = 1;
   localparam int unsigned CTRL_CLEAR = 2;

endpackage

// File: rtl/range_sensor_sync.sv
// Two-flop synchronizer for the asynchronous echo input.
module range_sensor_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/range_sensor_slot_core.sv
// Slot responder for one ultrasonic range sensor: register decode,
// trigger generation and echo width measurement with timeout.
module range_sensor_slot_core
   import range_sensor_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 3_800_000,
   parameter int unsigned HOLDOFF_CYCLES = 6_000_000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cs_i,
   input  logic        wr_i,
   input  logic        rd_i,
   input  logic [2:0]  addr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] rd_data_o,
   input  logic        echo_i,
   output logic        trig_o
);

   localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
   localparam logic [31:0] WAIT_LAST    = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] MEAS_LIMIT   = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);

   state_e      state_q;
   logic [31:0] cnt_q;
   logic [31:0] width_q;
   logic [31:0] count_q;
   logic        trig_q;
   logic        done_q;
   logic        timeout_q;
   logic        auto_en_q;

   logic echo_s;
   logic ctrl_wr;
   logic start_req;
   logic clear_req;
   logic unused_ok;

   range_sensor_sync u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (echo_i),
      .q_o     (echo_s)
   );

   assign ctrl_wr   = cs_i & wr_i & (addr_i == REG_CTRL);
   assign start_req = ctrl_wr & wr_data_i[CTRL_START];
   assign clear_req = ctrl_wr & wr_data_i[CTRL_CLEAR];
   assign unused_ok = ^{rd_i, wr_data_i[31:3]};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         trig_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         auto_en_q <= 1'b0;
         width_q   <= '0;
         count_q   <= '0;
      end else begin
         if (ctrl_wr) auto_en_q <= wr_data_i[CTRL_AUTO];
         // Clear is applied first so a completion in the same cycle overrides it.
         if (clear_req) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start_req || auto_en_q) begin
                  state_q <= TRIG;
                  cnt_q   <= '0;
                  trig_q  <= 1'b1;
               end
            end
            TRIG: begin
               if (cnt_q == TRIG_LAST) begin
                  state_q <= WAIT_RISE;
                  cnt_q   <= '0;
                  trig_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            WAIT_RISE: begin
               if (echo_s) begin
                  state_q <= MEASURE;
                  cnt_q   <= 32'd1;
               end else if (cnt_q == WAIT_LAST) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b0;
                  width_q   <= '0;
                  count_q   <= count_q + 32'd1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            MEASURE: begin
               if (!echo_s) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  width_q   <= cnt_q;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b0;
                  count_q   <= count_q + 32'd1;
               end else if (cnt_q == MEAS_LIMIT) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  width_q   <= MEAS_LIMIT;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  count_q   <= count_q + 32'd1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            HOLDOFF: begin
               if (cnt_q == HOLDOFF_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               trig_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_data_o = '0;
      case (addr_i)
         REG_STATUS: begin
            rd_data_o[ST_BUSY]    = (state_q != IDLE);
            rd_data_o[ST_DONE]    = done_q;
            rd_data_o[ST_TIMEOUT] = timeout_q;
            rd_data_o[ST_AUTO]    = auto_en_q;
         end
         REG_WIDTH: rd_data_o = width_q;
         REG_COUNT: rd_data_o = count_q;
         default:   rd_data_o = '0;
      endcase
   end

   assign trig_o = trig_q;

endmodule

// File: tb/tb_range_sensor_slot_core.sv
// Randomized scoreboard bench for range_sensor_slot_core with a measurement-level model.
module tb_range_sensor_slot_core;
   import range_sensor_pkg::*;

   localparam int TRIG = 10;
   localparam int TMO  = 200;
   localparam int HOLD = 50;

   logic        clk = 1'b0;
   logic        reset, cs, wr, rd, echo, trig;
   logic [2:0]  addr;
   logic [31:0] wdata, rdata;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct { string name; logic [31:0] val; } exp_t;
   typedef struct { int rise; int len; } tpulse_t;
   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   tpulse_t     tq[$];

   int m_count = 0;
   int m_width = 0;
   bit m_done = 0, m_tmo = 0, m_auto = 0;

   range_sensor_slot_core #(
      .TRIG_CYCLES    (TRIG),
      .TIMEOUT_CYCLES (TMO),
      .HOLDOFF_CYCLES (HOLD)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .cs_i      (cs),
      .wr_i      (wr),
      .rd_i      (rd),
      .addr_i    (addr),
      .wr_data_i (wdata),
      .rd_data_o (rdata),
      .echo_i    (echo),
      .trig_o    (trig)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-read scoreboard
   logic [31:0] mon_a;
   exp_t        mon_e;
   always @(negedge clk) begin
      while (obs_q.size() > 0) begin
         mon_a = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read got=0x%08h exp=none", mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e.val) begin
               errors++;
               $display("FAIL %s got=0x%08h exp=0x%08h", mon_e.name, mon_a, mon_e.val);
            end
         end
      end
   end

   // Trigger pulse monitor: rise cycle and high time
   logic    trig_prev = 1'b0;
   int      rise_at = 0;
   tpulse_t tp;
   always @(negedge clk) begin
      if (trig === 1'b1 && !trig_prev) rise_at = cyc;
      if (trig !== 1'b1 && trig_prev) begin
         checks++;
         if (tq.size() == 0) begin
            errors++;
            $display("FAIL trig_unexpected got=rise%0d/len%0d exp=none", rise_at, cyc - rise_at);
         end else begin
            tp = tq.pop_front();
            if (rise_at != tp.rise || (cyc - rise_at) != tp.len) begin
               errors++;
               $display("FAIL trig_pulse got=rise%0d/len%0d exp=rise%0d/len%0d",
                        rise_at, cyc - rise_at, tp.rise, tp.len);
            end
         end
      end
      trig_prev = (trig === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] status_exp();
      return {28'd0, m_auto, m_tmo, m_done, 1'b0};
   endfunction

   function automatic void model_complete(input int len);
      m_count++;
      if (len == 0) begin
         m_tmo = 1; m_done = 0; m_width = 0;
      end else if (len <= TMO) begin
         m_done = 1; m_tmo = 0; m_width = len;
      end else begin
         m_tmo = 1; m_done = 0; m_width = TMO;
      end
   endfunction

   task automatic expect_trig(input int rise);
      tpulse_t t;
      t.rise = rise;
      t.len  = TRIG;
      tq.push_back(t);
   endtask

   task automatic fail_now(input string what);
      checks++;
      errors++;
      $display("FAIL %s got=no_event exp=event", what);
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [31:0] d, output int c);
      @(negedge clk);
      cs = 1; wr = 1; addr = a; wdata = d; c = cyc;
      @(negedge clk);
      cs = 0; wr = 0;
   endtask

   task automatic raw_read(input logic [2:0] a, output logic [31:0] v);
      addr = a; cs = 1; rd = 1;
      #1;
      v = rdata;
      cs = 0; rd = 0;
   endtask

   task automatic check_read(input string name, input logic [2:0] a, input logic [31:0] e);
      exp_t x;
      logic [31:0] v;
      x.name = name;
      x.val  = e;
      exp_q.push_back(x);
      raw_read(a, v);
      obs_q.push_back(v);
   endtask

   task automatic wait_trig(input logic lvl, input string what);
      int n = 0;
      while (trig !== lvl && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (trig !== lvl) fail_now(what);
   endtask

   task automatic wait_idle();
      logic [31:0] v;
      int n = 0;
      raw_read(REG_STATUS, v);
      while (v[0] && n < 2000) begin
         @(negedge clk);
         raw_read(REG_STATUS, v);
         n++;
      end
      if (v[0]) fail_now("idle_wait");
   endtask

   task automatic echo_pulse(input int len, input int wr_at, input logic [31:0] wd, output int c_fall);
      echo = 1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == wr_at) begin
            cs = 1; wr = 1; addr = REG_CTRL; wdata = wd;
         end else begin
            cs = 0; wr = 0;
         end
      end
      echo = 0; cs = 0; wr = 0;
      c_fall = cyc;
   endtask

   task automatic check_results();
      check_read("status", REG_STATUS, status_exp());
      check_read("width", REG_WIDTH, m_width);
      check_read("count", REG_COUNT, m_count);
   endtask

   task automatic run_meas(input logic [31:0] sw, input int d, input int len, input int start_at);
      int c;
      write_reg(REG_CTRL, sw, c);
      expect_trig(c + 1);
      m_auto = sw[1];
      if (sw[2]) begin
         m_done = 0; m_tmo = 0;
      end
      check_read("status_busy", REG_STATUS, status_exp() | 32'h1);
      wait_trig(1'b1, "trig_rise");
      wait_trig(1'b0, "trig_fall");
      repeat (d) @(negedge clk);
      if (len > 0) echo_pulse(len, start_at, 32'h1, c);
      wait_idle();
      model_complete(len);
      check_results();
   endtask

   initial begin
      int c;
      reset = 1; cs = 0; wr = 0; rd = 0; echo = 0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      reset = 0;
      check_results();
      check_read("unmapped_addr", 3'd5, 32'h0);

      // Writes to a non-control address must not start or enable anything
      write_reg(3'd3, 32'h7, c);
      repeat (20) @(negedge clk);
      check_read("status_after_bad_addr", REG_STATUS, 32'h0);

      run_meas(32'h1, 15, 40, -1);
      run_meas(32'h1, 0, 0, -1);
      run_meas(32'h5, $urandom_range(0, 100), 50, -1);
      run_meas(32'h1, 5, 300, -1);
      run_meas(32'h1, 3, TMO, -1);
      run_meas(32'h1, 3, TMO + 1, -1);
      run_meas(32'h1, 20, 60, 30);
      for (int i = 0; i < 5; i++)
         run_meas(32'h1, $urandom_range(0, 100), $urandom_range(1, 230), -1);

      write_reg(REG_CTRL, 32'h4, c);
      m_done = 0; m_tmo = 0; m_auto = 0;
      check_read("status_cleared", REG_STATUS, status_exp());

      // Auto mode: three back-to-back measurements, auto_en dropped mid-third
      m_auto = 1;
      write_reg(REG_CTRL, 32'h2, c);
      expect_trig(c + 2);
      for (int m = 0; m < 3; m++) begin
         wait_trig(1'b1, "auto_trig_rise");
         wait_trig(1'b0, "auto_trig_fall");
         repeat ($urandom_range(0, 30)) @(negedge clk);
         echo_pulse(20, (m == 2) ? 5 : -1, 32'h0, c);
         model_complete(20);
         if (m < 2) expect_trig(c + HOLD + 4);
      end
      m_auto = 0;
      wait_idle();
      repeat (100) @(negedge clk);
      check_results();

      // Clear write landing on the completion edge
      write_reg(REG_CTRL, 32'h1, c);
      expect_trig(c + 1);
      wait_trig(1'b1, "clr_trig_rise");
      wait_trig(1'b0, "clr_trig_fall");
      echo_pulse(30, -1, 32'h0, c);
      @(negedge clk);
      @(negedge clk);
      cs = 1; wr = 1; addr = REG_CTRL; wdata = 32'h4;
      @(negedge clk);
      cs = 0; wr = 0;
      wait_idle();
      model_complete(30);
      check_results();

      // Reset in the middle of MEASURE
      write_reg(REG_CTRL, 32'h1, c);
      expect_trig(c + 1);
      wait_trig(1'b1, "rst_trig_rise");
      wait_trig(1'b0, "rst_trig_fall");
      echo = 1;
      repeat (10) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      m_count = 0; m_width = 0; m_done = 0; m_tmo = 0; m_auto = 0;
      check_results();
      begin
         exp_t x;
         x.name = "trig_after_reset";
         x.val  = 32'h0;
         exp_q.push_back(x);
         obs_q.push_back({31'd0, trig});
      end
      echo = 0;
      repeat (5) @(negedge clk);

      run_meas(32'h1, $urandom_range(0, 100), $urandom_range(1, 150), -1);

      repeat (3) @(negedge clk);
      checks++;
      if (tq.size() != 0) begin
         errors++;
         $display("FAIL trig_missing got=%0d_pending exp=0_pending", tq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
